// File: rtl/sauto_nav_ctrl.sv
// Semi-automatic navigation controller: filtered detectors, fork handling,
// timed 90/180-degree turns, dead-end recovery and abort on disable.
module sauto_nav_ctrl #(
  parameter int unsigned FRONT_FILT_CYC = 5_000_000,
  parameter int unsigned CHECK_CYC      = 100_000_000,
  parameter int unsigned TURN90_CYC     = 90_000_000,
  parameter int unsigned CNT_W          = $clog2(2*TURN90_CYC+1)
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       det_front,
  input  logic       det_left,
  input  logic       det_right,
  input  logic       cmd_forward,
  input  logic       cmd_left,
  input  logic       cmd_right,
  input  logic       cmd_back,
  output logic       move_forward,
  output logic       turn_left,
  output logic       turn_right,
  output logic       wait_flag,
  output logic       fork_here,
  output logic       turn_done,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MOVE  = 3'd1,
    WAIT  = 3'd2,
    TURN  = 3'd3,
    CHECK = 3'd4
  } state_e;

  typedef enum logic {DIR_L = 1'b0, DIR_R = 1'b1} dir_e;

  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FRONT_FILT_CYC - 1);
  localparam logic [CNT_W-1:0] CHK_LAST  = CNT_W'(CHECK_CYC - 1);
  localparam logic [CNT_W-1:0] T90_LAST  = CNT_W'(TURN90_CYC - 1);
  localparam logic [CNT_W-1:0] T180_LAST = CNT_W'(2*TURN90_CYC - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  dir_e             turn_dir_q, turn_dir_d;
  logic             turn_180_q, turn_180_d;
  logic             turn_auto_q, turn_auto_d;
  logic [CNT_W-1:0] filt_q, filt_d;
  // TURN and CHECK are never active together, so they share one counter.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             front_blk_q, front_blk_d;
  logic             fork_q, fork_d, fork_dly_q;
  logic             det_l_q, det_r_q;
  logic             just_turned_q, just_turned_d;
  logic             fork_rise, fork_fall, turn_last, det_changed;

  assign fork_rise   = fork_q & ~fork_dly_q;
  assign fork_fall   = ~fork_q & fork_dly_q;
  assign turn_last   = turn_180_q ? (cnt_q == T180_LAST) : (cnt_q == T90_LAST);
  assign det_changed = (det_left != det_l_q) | (det_right != det_r_q);

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    turn_dir_d    = turn_dir_q;
    turn_180_d    = turn_180_q;
    turn_auto_d   = turn_auto_q;
    cnt_d         = cnt_q;
    just_turned_d = just_turned_q;
    fork_d        = ((~front_blk_q & ~det_left) | (~front_blk_q & ~det_right) |
                     (~det_left & ~det_right));

    if (det_front) begin
      filt_d      = sat_inc(filt_q);
      front_blk_d = front_blk_q | (filt_q >= FILT_LAST);
    end else begin
      filt_d      = '0;
      front_blk_d = 1'b0;
    end

    if (fork_fall) just_turned_d = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = MOVE;
        MOVE: begin
          if (fork_rise && !just_turned_q)  state_d = WAIT;
          else if (front_blk_q && !fork_q)  state_d = CHECK;
        end
        WAIT: begin
          if (cmd_forward) begin
            state_d       = MOVE;
            just_turned_d = 1'b1;
          end else if (cmd_left || cmd_right || cmd_back) begin
            state_d     = TURN;
            turn_auto_d = 1'b0;
            turn_dir_d  = (!cmd_left && cmd_right) ? DIR_R : DIR_L;
            turn_180_d  = !cmd_left && !cmd_right;
          end
        end
        TURN: begin
          cnt_d = sat_inc(cnt_q);
          if (turn_last) begin
            just_turned_d = 1'b1;
            state_d       = (turn_auto_q && front_blk_q) ? CHECK : MOVE;
          end
        end
        CHECK: begin
          cnt_d = sat_inc(cnt_q);
          if (det_changed) begin
            cnt_d = '0;
          end else if (cnt_q == CHK_LAST) begin
            turn_auto_d = 1'b1;
            turn_180_d  = 1'b0;
            if (!det_left && det_right)       begin state_d = TURN; turn_dir_d = DIR_L; end
            else if (det_left && !det_right)  begin state_d = TURN; turn_dir_d = DIR_R; end
            else if (!det_left && !det_right) state_d = MOVE;
            else begin
              state_d    = TURN;
              turn_dir_d = DIR_L;
              turn_180_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d != state_q || state_q == IDLE) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments and the async active-low reset.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      turn_dir_q    <= DIR_L;
      turn_180_q    <= 1'b0;
      turn_auto_q   <= 1'b0;
      filt_q        <= '0;
      cnt_q         <= '0;
      front_blk_q   <= 1'b0;
      fork_q        <= 1'b0;
      fork_dly_q    <= 1'b0;
      det_l_q       <= 1'b0;
      det_r_q       <= 1'b0;
      just_turned_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      turn_dir_q    <= turn_dir_d;
      turn_180_q    <= turn_180_d;
      turn_auto_q   <= turn_auto_d;
      filt_q        <= filt_d;
      cnt_q         <= cnt_d;
      front_blk_q   <= front_blk_d;
      fork_q        <= fork_d;
      fork_dly_q    <= fork_q;
      det_l_q       <= det_left;
      det_r_q       <= det_right;
      just_turned_q <= just_turned_d;
    end
  end

  assign state_o      = state_q;
  assign move_forward = (state_q == MOVE);
  assign wait_flag    = (state_q == WAIT);
  assign turn_left    = (state_q == TURN) && (turn_dir_q == DIR_L);
  assign turn_right   = (state_q == TURN) && (turn_dir_q == DIR_R);
  assign fork_here    = fork_q;
  assign turn_done    = (state_q == TURN) && turn_last && enable;

endmodule

// File: tb/tb_sauto_nav_ctrl.sv
// Directed bench for sauto_nav_ctrl with small cycle parameters (4/8/10).
module tb_sauto_nav_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       det_front = 1'b0, det_left = 1'b0, det_right = 1'b0;
  logic       cmd_forward = 1'b0, cmd_left = 1'b0, cmd_right = 1'b0, cmd_back = 1'b0;
  logic       move_forward, turn_left, turn_right, wait_flag, fork_here, turn_done;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  sauto_nav_ctrl #(
    .FRONT_FILT_CYC(4),
    .CHECK_CYC     (8),
    .TURN90_CYC    (10)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .enable      (enable),
    .det_front   (det_front),
    .det_left    (det_left),
    .det_right   (det_right),
    .cmd_forward (cmd_forward),
    .cmd_left    (cmd_left),
    .cmd_right   (cmd_right),
    .cmd_back    (cmd_back),
    .move_forward(move_forward),
    .turn_left   (turn_left),
    .turn_right  (turn_right),
    .wait_flag   (wait_flag),
    .fork_here   (fork_here),
    .turn_done   (turn_done),
    .state_o     (state_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st,
                            input logic mf, input logic tl, input logic tr,
                            input logic wf, input logic td);
    check({tag, ".state"}, 32'(state_o), 32'(st));
    check({tag, ".outs"}, {27'd0, move_forward, turn_left, turn_right, wait_flag, turn_done},
          {27'd0, mf, tl, tr, wf, td});
  endtask

  // Toggle det_left 1 then 0 so a fork fall clears just_turned and the next rise reaches WAIT.
  task automatic reach_wait(input string tag);
    det_left = 1'b1;
    step(2);
    det_left = 1'b0;
    step(2);
    check_outs(tag, 3'd2, 0, 0, 0, 1, 0);
  endtask

  initial begin
    #2;
    check_outs("reset", 3'd0, 0, 0, 0, 0, 0);
    check("reset.fork", 32'(fork_here), 32'd0);
    #20 rst = 1'b1;
    step(3);
    check_outs("idle", 3'd0, 0, 0, 0, 0, 0);
    check("idle.fork", 32'(fork_here), 32'd1);

    // 1. enable -> MOVE after one edge
    enable = 1'b1;
    step(1);
    check_outs("t1.move", 3'd1, 1, 0, 0, 0, 0);

    // 2. dead end: front filter 4 cycles, CHECK on the 5th edge, then 8 cycles -> L180
    det_front = 1'b1; det_left = 1'b1; det_right = 1'b1;
    step(4);
    check_outs("t2.filtering", 3'd1, 1, 0, 0, 0, 0);
    step(1);
    check_outs("t2.check", 3'd4, 0, 0, 0, 0, 0);
    step(7);
    check_outs("t2.check_last", 3'd4, 0, 0, 0, 0, 0);
    step(1);
    check_outs("t2.turn_c0", 3'd3, 0, 1, 0, 0, 0);
    step(18);
    check_outs("t2.turn_c18", 3'd3, 0, 1, 0, 0, 0);
    step(1);
    check_outs("t2.turn_c19", 3'd3, 0, 1, 0, 0, 1);
    step(1);
    check_outs("t2.recheck", 3'd4, 0, 0, 0, 0, 0);

    // 4. toggle det_left at check cycle 5: decision moves to 8 cycles after the toggle
    step(5);
    det_left = 1'b0;
    step(8);
    check_outs("t4.still_check", 3'd4, 0, 0, 0, 0, 0);
    step(1);
    check_outs("t4.auto_l90", 3'd3, 0, 1, 0, 0, 0);
    det_front = 1'b0;
    step(9);
    check_outs("t4.turn_last", 3'd3, 0, 1, 0, 0, 1);
    step(1);
    check_outs("t4.move", 3'd1, 1, 0, 0, 0, 0);

    // 3. fork -> WAIT, cmd_right -> 10-cycle right turn -> MOVE with just_turned
    reach_wait("t3.wait");
    step(3);
    check_outs("t3.wait_hold", 3'd2, 0, 0, 0, 1, 0);
    cmd_right = 1'b1;
    step(1);
    cmd_right = 1'b0;
    det_left = 1'b1;
    check_outs("t3.turn_r", 3'd3, 0, 0, 1, 0, 0);
    step(8);
    check_outs("t3.turn_c8", 3'd3, 0, 0, 1, 0, 0);
    step(1);
    check_outs("t3.turn_c9", 3'd3, 0, 0, 1, 0, 1);
    step(1);
    check_outs("t3.move", 3'd1, 1, 0, 0, 0, 0);
    det_left = 1'b0;
    step(4);
    check_outs("t3.rise_ignored", 3'd1, 1, 0, 0, 0, 0);
    check("t3.fork", 32'(fork_here), 32'd1);

    // 5. cmd_left beats cmd_back (90 not 180); cmd_forward beats everything
    reach_wait("t5.wait_a");
    cmd_left = 1'b1; cmd_back = 1'b1;
    step(1);
    cmd_left = 1'b0; cmd_back = 1'b0;
    check_outs("t5.turn_l", 3'd3, 0, 1, 0, 0, 0);
    step(9);
    check_outs("t5.turn_c9", 3'd3, 0, 1, 0, 0, 1);
    step(1);
    check_outs("t5.move", 3'd1, 1, 0, 0, 0, 0);
    reach_wait("t5.wait_b");
    cmd_forward = 1'b1; cmd_left = 1'b1; cmd_right = 1'b1; cmd_back = 1'b1;
    step(1);
    cmd_forward = 1'b0; cmd_left = 1'b0; cmd_right = 1'b0; cmd_back = 1'b0;
    check_outs("t5.fwd", 3'd1, 1, 0, 0, 0, 0);

    // 6. cmd_back -> L180, abort at cycle 3 by dropping enable
    reach_wait("t6.wait");
    cmd_back = 1'b1;
    step(1);
    cmd_back = 1'b0;
    check_outs("t6.turn_back", 3'd3, 0, 1, 0, 0, 0);
    step(3);
    enable = 1'b0;
    check("t6.no_done_c3", 32'(turn_done), 32'd0);
    step(1);
    check_outs("t6.abort", 3'd0, 0, 0, 0, 0, 0);
    step(25);
    check_outs("t6.idle_hold", 3'd0, 0, 0, 0, 0, 0);

    // 6b. asynchronous reset in the middle of CHECK
    enable = 1'b1;
    step(1);
    check_outs("t6.re_move", 3'd1, 1, 0, 0, 0, 0);
    det_front = 1'b1; det_left = 1'b1; det_right = 1'b1;
    step(5);
    check_outs("t6.check", 3'd4, 0, 0, 0, 0, 0);
    step(3);
    #2 rst = 1'b0;
    #1;
    check_outs("t6.rst_async", 3'd0, 0, 0, 0, 0, 0);
    check("t6.rst_fork", 32'(fork_here), 32'd0);
    step(2);
    check_outs("t6.rst_hold", 3'd0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
